// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    // Bit offset of channel ch inside a packed per-channel duty vector.
    function automatic int duty_slice(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator shared by all PWM channels: one tick every prescale+1 clocks.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic               clk_50mhz,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] PSC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] psc_r;
    logic [PRESC_W-1:0] psc_nxt_s;

    // Next prescaler count; a live prescale below psc forces a silent wrap.
    always_comb begin
        psc_nxt_s = psc_r;
        if (!enable) begin
            psc_nxt_s = '0;
        end else if (psc_r >= prescale) begin
            psc_nxt_s = '0;
        end else begin
            psc_nxt_s = psc_r + PSC_ONE;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            psc_r <= '0;
        end else begin
            psc_r <= psc_nxt_s;
        end
    end

    assign tick = enable && (psc_r == prescale);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter (edge or center aligned),
// per-channel compare/polarity, configuration double-buffered to period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic                    clk_50mhz,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic                    cfg_load,
    input  logic [CNT_W-1:0]        period_in,
    input  logic [NUM_CH*CNT_W-1:0] duty_in,
    input  logic [NUM_CH-1:0]       polarity_in,
    input  logic                    center_in,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start,
    output logic                    load_pending,
    output logic [CNT_W-1:0]        cnt_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]        sh_per_r;
    logic [NUM_CH*CNT_W-1:0] sh_duty_r;
    logic [NUM_CH-1:0]       sh_pol_r;
    logic                    sh_mode_r;
    logic [CNT_W-1:0]        act_per_r;
    logic [NUM_CH*CNT_W-1:0] act_duty_r;
    logic [NUM_CH-1:0]       act_pol_r;
    logic                    act_mode_r;
    logic                    load_pending_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    dir_r;
    logic [NUM_CH-1:0]       pwm_r;
    logic                    period_start_r;

    logic                    tick_s;
    logic                    center_eff_s;
    logic                    boundary_s;
    logic                    apply_s;
    logic                    pending_nxt_s;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic                    dir_nxt_s;
    logic [NUM_CH-1:0]       raw_s;
    logic [NUM_CH-1:0]       pwm_nxt_s;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .enable    (enable),
        .prescale  (prescale),
        .tick      (tick_s)
    );

    // Boundary detection; center mode with P<=1 degenerates to edge counting.
    always_comb begin
        center_eff_s = 1'b0;
        boundary_s   = 1'b0;
        if ((act_mode_r == MODE_EDGE) || (act_per_r <= CNT_ONE)) begin
            center_eff_s = 1'b0;
        end else begin
            center_eff_s = 1'b1;
        end
        if (!tick_s) begin
            boundary_s = 1'b0;
        end else if (center_eff_s) begin
            boundary_s = (dir_r == DIR_DOWN) && (cnt_r == CNT_ONE);
        end else begin
            boundary_s = (cnt_r == act_per_r);
        end
    end

    // Shadow-to-active transfer happens at a boundary or at once while disabled.
    always_comb begin
        apply_s       = load_pending_r && (boundary_s || !enable);
        pending_nxt_s = load_pending_r;
        if (cfg_load) begin
            pending_nxt_s = 1'b1;
        end else if (apply_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = load_pending_r;
        end
    end

    // Shadow and active configuration registers.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            sh_per_r       <= '0;
            sh_duty_r      <= '0;
            sh_pol_r       <= '0;
            sh_mode_r      <= 1'b0;
            act_per_r      <= '0;
            act_duty_r     <= '0;
            act_pol_r      <= '0;
            act_mode_r     <= 1'b0;
            load_pending_r <= 1'b0;
        end else begin
            if (cfg_load) begin
                sh_per_r  <= period_in;
                sh_duty_r <= duty_in;
                sh_pol_r  <= polarity_in;
                sh_mode_r <= center_in;
            end
            if (apply_s) begin
                act_per_r  <= sh_per_r;
                act_duty_r <= sh_duty_r;
                act_pol_r  <= sh_pol_r;
                act_mode_r <= sh_mode_r;
            end
            load_pending_r <= pending_nxt_s;
        end
    end

    // Counter/direction next state.
    always_comb begin
        cnt_nxt_s = cnt_r;
        dir_nxt_s = dir_r;
        if (!enable) begin
            cnt_nxt_s = '0;
            dir_nxt_s = DIR_UP;
        end else if (!tick_s) begin
            cnt_nxt_s = cnt_r;
            dir_nxt_s = dir_r;
        end else if (boundary_s) begin
            cnt_nxt_s = '0;
            dir_nxt_s = DIR_UP;
        end else if (!center_eff_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            dir_nxt_s = DIR_UP;
        end else if (dir_r == DIR_UP) begin
            if (cnt_r >= act_per_r) begin
                cnt_nxt_s = act_per_r - CNT_ONE;
                dir_nxt_s = DIR_DOWN;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
                dir_nxt_s = DIR_UP;
            end
        end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
            dir_nxt_s = DIR_DOWN;
        end
    end

    // Counter and direction registers.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            dir_r <= DIR_UP;
        end else begin
            cnt_r <= cnt_nxt_s;
            dir_r <= dir_nxt_s;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int OFS = duty_slice(i, CNT_W);
        assign raw_s[i] = (cnt_r < act_duty_r[OFS +: CNT_W]);
    end

    // Output levels: polarity applied to compare, inactive level when disabled.
    always_comb begin
        pwm_nxt_s = act_pol_r;
        if (enable) begin
            pwm_nxt_s = raw_s ^ act_pol_r;
        end else begin
            pwm_nxt_s = act_pol_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r          <= '0;
            period_start_r <= 1'b0;
        end else begin
            pwm_r          <= pwm_nxt_s;
            period_start_r <= boundary_s;
        end
    end

    assign pwm_out      = pwm_r;
    assign period_start = period_start_r;
    assign load_pending = load_pending_r;
    assign cnt_out      = cnt_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed, table-driven bench for pwm_multi (4 channels, 16-bit counter).
module tb_pwm_multi;

    logic        clk_50mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  prescale = 8'd0;
    logic        cfg_load = 1'b0;
    logic [15:0] period_in = 16'd0;
    logic [63:0] duty_in = 64'd0;
    logic [3:0]  polarity_in = 4'd0;
    logic        center_in = 1'b0;
    logic [3:0]  pwm_out;
    logic        period_start;
    logic        load_pending;
    logic [15:0] cnt_out;

    int n_cmp = 0;
    int n_err = 0;
    int m_n;
    int m_hi [4];
    logic m_pend_all;
    logic m_pend_end;
    int hi0;

    typedef struct {
        logic             center;
        logic [7:0]       psc;
        logic [15:0]      per;
        logic [3:0][15:0] d;
        logic [3:0]       pol;
        logic [15:0]      exp_n;
        logic [3:0][15:0] exp_hi;
    } vec_t;

    vec_t vecs [6];

    pwm_multi #(.NUM_CH(4), .CNT_W(16), .PRESC_W(8)) dut (
        .clk_50mhz    (clk_50mhz),
        .rst_n        (rst_n),
        .enable       (enable),
        .prescale     (prescale),
        .cfg_load     (cfg_load),
        .period_in    (period_in),
        .duty_in      (duty_in),
        .polarity_in  (polarity_in),
        .center_in    (center_in),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .load_pending (load_pending),
        .cnt_out      (cnt_out)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_50mhz);
    endtask

    task automatic drive_cfg(input logic ctr, input logic [7:0] psc, input logic [15:0] per,
                             input logic [63:0] duty, input logic [3:0] pol);
        center_in   = ctr;
        prescale    = psc;
        period_in   = per;
        duty_in     = duty;
        polarity_in = pol;
    endtask

    task automatic apply_cfg(input logic ctr, input logic [7:0] psc, input logic [15:0] per,
                             input logic [63:0] duty, input logic [3:0] pol);
        enable = 1'b0;
        drive_cfg(ctr, psc, per, duty, pol);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        step();
        step();
    endtask

    task automatic wait_start(input string name);
        int k;
        k = 0;
        step();
        while (period_start !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        if (period_start !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no period_start within 200 clocks", name);
        end
    endtask

    // Runs up to and including the next period_start sample.
    task automatic measure(input string name);
        logic done;
        done = 1'b0;
        m_n = 0;
        m_pend_all = 1'b1;
        m_pend_end = 1'b0;
        for (int c = 0; c < 4; c++) m_hi[c] = 0;
        while (!done && m_n < 200) begin
            step();
            m_n++;
            for (int c = 0; c < 4; c++) if (pwm_out[c]) m_hi[c]++;
            if (period_start === 1'b1) begin
                done = 1'b1;
                m_pend_end = load_pending;
            end else begin
                m_pend_all = m_pend_all & load_pending;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: period did not end within 200 clocks", name);
        end
    endtask

    initial begin
        vecs[0] = '{center:1'b0, psc:8'd0, per:16'd9, d:{16'd9, 16'd10, 16'd3, 16'd0},
                    pol:4'b0000, exp_n:16'd10, exp_hi:{16'd9, 16'd10, 16'd3, 16'd0}};
        vecs[1] = '{center:1'b1, psc:8'd1, per:16'd4, d:{16'd4, 16'd5, 16'd0, 16'd2},
                    pol:4'b0000, exp_n:16'd16, exp_hi:{16'd14, 16'd16, 16'd0, 16'd6}};
        vecs[2] = '{center:1'b0, psc:8'd2, per:16'd3, d:{16'd0, 16'd4, 16'd2, 16'd1},
                    pol:4'b0101, exp_n:16'd12, exp_hi:{16'd0, 16'd0, 16'd6, 16'd9}};
        vecs[3] = '{center:1'b1, psc:8'd0, per:16'd1, d:{16'd1, 16'd0, 16'd2, 16'd1},
                    pol:4'b0000, exp_n:16'd2, exp_hi:{16'd1, 16'd0, 16'd2, 16'd1}};
        vecs[4] = '{center:1'b0, psc:8'd0, per:16'd0, d:{16'd0, 16'd1, 16'd1, 16'd0},
                    pol:4'b0000, exp_n:16'd1, exp_hi:{16'd0, 16'd1, 16'd1, 16'd0}};
        vecs[5] = '{center:1'b1, psc:8'd0, per:16'd3, d:{16'd2, 16'd4, 16'd3, 16'd1},
                    pol:4'b0000, exp_n:16'd6, exp_hi:{16'd3, 16'd6, 16'd5, 16'd1}};

        // Reset and idle
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_pwm", 32'(pwm_out), 32'd0);
            check("idle_cnt", 32'(cnt_out), 32'd0);
            check("idle_pending", 32'(load_pending), 32'd0);
            check("idle_pstart", 32'(period_start), 32'd0);
        end

        // Cycle-exact start of edge mode, P=9
        apply_cfg(1'b0, 8'd0, 16'd9, {16'd9, 16'd10, 16'd3, 16'd0}, 4'b0000);
        check("cfg_applied_pending", 32'(load_pending), 32'd0);
        enable = 1'b1;
        for (int m = 0; m < 12; m++) begin
            step();
            check($sformatf("edge_cnt_m%0d", m), 32'(cnt_out), 32'((m + 1) % 10));
            check($sformatf("edge_pstart_m%0d", m), 32'(period_start), (m == 9) ? 32'd1 : 32'd0);
            if (m == 0) check("edge_pwm_m0", 32'(pwm_out), 32'b1110);
            if (m == 3) check("edge_pwm_m3", 32'(pwm_out), 32'b1100);
            if (m == 9) check("edge_pwm_m9", 32'(pwm_out), 32'b0100);
        end

        // Table of steady-state period length and per-channel high time
        for (int v = 0; v < 6; v++) begin
            apply_cfg(vecs[v].center, vecs[v].psc, vecs[v].per, vecs[v].d, vecs[v].pol);
            enable = 1'b1;
            wait_start($sformatf("vec%0d_sync", v));
            measure($sformatf("vec%0d_meas", v));
            check($sformatf("vec%0d_period", v), 32'(m_n), 32'(vecs[v].exp_n));
            for (int c = 0; c < 4; c++)
                check($sformatf("vec%0d_high_ch%0d", v, c), 32'(m_hi[c]), 32'(vecs[v].exp_hi[c]));
        end

        // Shadow timing: D 5 -> 2 loaded at cnt=4
        apply_cfg(1'b0, 8'd0, 16'd9, {4{16'd5}}, 4'b0000);
        enable = 1'b1;
        wait_start("shadow_sync");
        hi0 = 0;
        repeat (4) begin
            step();
            if (pwm_out[0]) hi0++;
        end
        check("shadow_cnt_at_load", 32'(cnt_out), 32'd4);
        duty_in = {4{16'd2}};
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        if (pwm_out[0]) hi0++;
        check("shadow_pending_set", 32'(load_pending), 32'd1);
        measure("shadow_cur");
        check("shadow_cur_high", 32'(hi0 + m_hi[0]), 32'd5);
        check("shadow_pending_held", 32'(m_pend_all), 32'd1);
        check("shadow_pending_clr", 32'(m_pend_end), 32'd0);
        measure("shadow_next");
        check("shadow_next_period", 32'(m_n), 32'd10);
        check("shadow_next_high", 32'(m_hi[0]), 32'd2);

        // Load coincident with boundary: D=7 pending, then D=1 written on the boundary
        repeat (3) step();
        check("bnd_cnt3", 32'(cnt_out), 32'd3);
        duty_in = {4{16'd7}};
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        repeat (5) step();
        check("bnd_cnt9", 32'(cnt_out), 32'd9);
        duty_in = {4{16'd1}};
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        check("bnd_pstart", 32'(period_start), 32'd1);
        check("bnd_pending_kept", 32'(load_pending), 32'd1);
        measure("bnd_old");
        check("bnd_old_high", 32'(m_hi[0]), 32'd7);
        check("bnd_old_period", 32'(m_n), 32'd10);
        check("bnd_old_pending_clr", 32'(m_pend_end), 32'd0);
        measure("bnd_new");
        check("bnd_new_high", 32'(m_hi[0]), 32'd1);

        // Polarity and disable mid-period
        apply_cfg(1'b0, 8'd0, 16'd9, {4{16'd5}}, 4'b0010);
        check("dis_idle_pwm", 32'(pwm_out), 32'b0010);
        enable = 1'b1;
        wait_start("dis_sync");
        repeat (4) step();
        check("dis_cnt4", 32'(cnt_out), 32'd4);
        check("dis_pwm_run", 32'(pwm_out), 32'b1101);
        enable = 1'b0;
        step();
        check("dis_cnt0", 32'(cnt_out), 32'd0);
        check("dis_pwm_inactive", 32'(pwm_out), 32'b0010);
        check("dis_pstart", 32'(period_start), 32'd0);
        period_in = 16'd5;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        check("dis_load_pending", 32'(load_pending), 32'd1);
        step();
        check("dis_load_applied", 32'(load_pending), 32'd0);

        // Asynchronous reset mid-period with inverted outputs and a pending load
        apply_cfg(1'b0, 8'd0, 16'd9, {4{16'd0}}, 4'b1111);
        enable = 1'b1;
        wait_start("rst_sync");
        repeat (3) step();
        check("rst_pwm_before", 32'(pwm_out), 32'b1111);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        check("rst_pending_before", 32'(load_pending), 32'd1);
        #5;
        rst_n = 1'b0;
        #1;
        check("rst_async_pwm", 32'(pwm_out), 32'd0);
        check("rst_async_cnt", 32'(cnt_out), 32'd0);
        check("rst_async_pending", 32'(load_pending), 32'd0);
        check("rst_async_pstart", 32'(period_start), 32'd0);
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rst_after_pwm", 32'(pwm_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; successor to the single-channel, fixed-period 50 MHz PWM.
- All channels share one period counter and one prescaler.
- Each channel has its own compare value and polarity.
- Supports edge-aligned and center-aligned counting.
- Configuration is double-buffered and takes effect only at a period boundary, so outputs never glitch.
- Sits between the control/register logic and the motor/LED driver pins.

Parameters:
- NUM_CH, 4, number of PWM output channels (1..16)
- CNT_W, 16, width of the period counter, period and duty values
- PRESC_W, 8, width of the prescaler divide value

Ports:
- clk_50mhz  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run control. 0 = counter held, outputs inactive.
- prescale  in  PRESC_W  tick divider, live (not shadowed). tick rate = clk/(prescale+1).
- cfg_load  in  1  single-cycle strobe; captures period_in, duty_in, polarity_in, center_in into shadow registers
- period_in  in  CNT_W  period value P
- duty_in  in  NUM_CH*CNT_W  per-channel compare value D[i]; channel i occupies bits [i*CNT_W +: CNT_W]
- polarity_in  in  NUM_CH  per channel: 0 = active-high, 1 = active-low
- center_in  in  1  0 = edge-aligned, 1 = center-aligned
- pwm_out  out  NUM_CH  registered PWM outputs
- period_start  out  1  one-cycle pulse at each period boundary
- load_pending  out  1  shadow holds values not yet applied
- cnt_out  out  CNT_W  current counter value, for debug and ADC triggering

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0 every register is 0:
  - pwm_out=0, period_start=0, load_pending=0, cnt_out=0
  - shadow and active period/duty/polarity/mode registers = 0
  - direction = up, prescaler count = 0
- Prescaler:
  - psc counts 0..prescale. tick=1 in the cycle psc==prescale, then psc wraps to 0.
  - prescale=0 gives tick every cycle.
  - If prescale changes below the current psc, psc wraps to 0 on the next cycle with no tick.
- Edge mode (active center=0):
  - Counter runs 0,1,..,P,0,... advancing on tick.
  - Period = P+1 ticks. Boundary = tick while cnt==P.
- Center mode (active center=1):
  - Counter runs 0 up to P, then down P-1..1, then 0. Period = 2P ticks.
  - Boundary = tick while dir=down and cnt==1.
  - Direction flips to down at cnt==P.
  - P=0 or P=1 in center mode behaves exactly as edge mode with the same P.
- Compare (per channel):
  - raw_i = (cnt < D[i]).
  - D=0 gives 0% duty. D>P (edge) or D>P (center) gives 100% duty.
  - pwm_out[i] <= raw_i XOR pol[i], registered: one clk of latency after cnt changes.
- Boundary actions, in the same clock edge:
  - cnt<=0, dir<=up.
  - If load_pending=1 before this cycle: active<=shadow, load_pending<=0.
  - period_start<=1 for exactly one cycle.
- Configuration load:
  - cfg_load=1 writes the shadow registers and sets load_pending=1.
  - cfg_load coincident with a boundary: the boundary applies the old shadow contents (if pending). The new values stay pending, load_pending=1, and apply at the next boundary.
  - Repeated cfg_load before a boundary: last write wins.
- Disable (enable=0):
  - cnt=0, dir=up, psc=0, period_start=0.
  - pwm_out[i] <= pol[i] (inactive level, using active polarity).
  - If load_pending=1, active<=shadow on the next clock and load_pending clears.
  - On enable 0->1 counting starts at cnt=0 with psc=0. No period_start pulse for that first period.
- Widths: all comparisons unsigned, CNT_W bits. No multiply. The counter never exceeds P; no overflow path.
- rst_n asserted mid-period: outputs go to 0 immediately (asynchronous), regardless of polarity.

Decomposition:
- Package pwm_pkg:
  - localparams MODE_EDGE=1'b0, MODE_CENTER=1'b1, DIR_UP=1'b0, DIR_DOWN=1'b1
  - function duty_slice(ch) returning the bit offset
- Sub-module pwm_prescaler (clk_50mhz, rst_n, enable, prescale -> tick).
- Per-channel compare/polarity logic is a generate loop in pwm_multi, not a separate module.

Test Plan:
- Reset/idle: rst_n=0 then 1, enable=0 -> pwm_out=0, cnt_out=0, load_pending=0, period_start never pulses.
- Edge mode, prescale=0: P=9, D={0,3,10,9}, pol=0, load then enable -> ch0 always 0, ch1 high 3 of 10 clks, ch2 always 1, ch3 high 9 of 10. period_start every 10 clks.
- Center mode, prescale=1: P=4, D[0]=2 -> counter 0,1,2,3,4,3,2,1 (each value held 2 clks), period 16 clks. ch0 high while cnt<2, i.e. 6 clks per period, symmetric about cnt=0.
- Shadow timing: running P=9/D=5, pulse cfg_load with D=2 at cnt=4 -> current period completes with 5 high clks, next period 2 high. load_pending stays high until the boundary clock.
- Load at boundary: cfg_load coincident with cnt==9 tick -> old shadow applies, load_pending remains 1, new value applies one period later.
- Polarity/disable and async reset: pol[1]=1, enable 1->0 mid-period -> pwm_out[1]=1, cnt_out=0 next clk. Assert rst_n low mid-period -> all outputs 0 without a clock edge.
